// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC owner with execute-driven redirect, drain and flush window
//
// Purpose:
//   Holds the architectural fetch PC. Steps it by 4 on fetch_advance, and on an
//   accepted execute redirect (ex_valid && ex_jump while running) loads the new
//   target. A non-cancellable in-flight fetch is waited out first (DRAIN), then
//   IF/ID is squashed for FLUSH_CYCLES cycles (FLUSH). Misaligned targets are
//   sent to TRAP_VECTOR and raise a one-cycle trap record.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ex_valid_i          execute result valid this cycle
//   ex_jump_i           instruction in execute transfers control
//   ex_target_i         computed branch/jump target
//   ex_pc_i             PC of the jumping instruction
//   fetch_advance_i     fetch consumed pc_out_o; step to pc_out_o + 4
//   fetch_busy_i        fetch has an outstanding non-cancellable request
//   fetch_resp_valid_i  outstanding request completes this cycle
//   pc_out_o            current fetch PC
//   flush_o             squash IF/ID and discard fetch responses
//   stall_fetch_o       fetch must not issue; advance is ignored
//   trap_valid_o        one-cycle misaligned-target trap pulse
//   trap_pc_o           ex_pc of the trapping jump
//   trap_tval_o         offending target
//   redirect_count_o    accepted redirects, trapped ones included

module pc_redirect_unit #(
   parameter logic [63:0] RESET_PC     = 64'h0,
   parameter logic [63:0] TRAP_VECTOR  = 64'h100,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid_i,
   input  logic             ex_jump_i,
   input  logic [63:0]      ex_target_i,
   input  logic [63:0]      ex_pc_i,
   input  logic             fetch_advance_i,
   input  logic             fetch_busy_i,
   input  logic             fetch_resp_valid_i,
   output logic [63:0]      pc_out_o,
   output logic             flush_o,
   output logic             stall_fetch_o,
   output logic             trap_valid_o,
   output logic [63:0]      trap_pc_o,
   output logic [63:0]      trap_tval_o,
   output logic [CNT_W-1:0] redirect_count_o
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [63:0]      pc_q, pc_d;
   logic [63:0]      new_pc_q, new_pc_d;
   logic             flush_q, flush_d;
   logic             stall_q, stall_d;
   logic             trap_valid_q, trap_valid_d;
   logic [63:0]      trap_pc_q, trap_pc_d;
   logic [63:0]      trap_tval_q, trap_tval_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             accept;
   logic             misaligned;
   logic [63:0]      target_pc;

   // Only requests seen while running are real; anything during DRAIN/FLUSH
   // belongs to a younger, already-squashed instruction.
   assign accept     = (state_q == S_RUN) && ex_valid_i && ex_jump_i;
   assign misaligned = (ex_target_i[1:0] != 2'b00);
   assign target_pc  = misaligned ? TRAP_VECTOR : ex_target_i;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_d         = pc_q;
      new_pc_d     = new_pc_q;
      trap_valid_d = 1'b0;
      trap_pc_d    = trap_pc_q;
      trap_tval_d  = trap_tval_q;
      count_d      = count_q;

      case (state_q)
         S_RUN: begin
            if (accept) begin
               // Redirect wins over a same-cycle advance.
               new_pc_d = target_pc;
               count_d  = count_q + CNT_W'(1);
               if (misaligned) begin
                  trap_valid_d = 1'b1;
                  trap_pc_d    = ex_pc_i;
                  trap_tval_d  = ex_target_i;
               end
               if (!fetch_busy_i || fetch_resp_valid_i) begin
                  pc_d    = target_pc;
                  state_d = S_FLUSH;
                  cnt_d   = FLUSH_INIT;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (fetch_advance_i) begin
               pc_d = pc_q + 64'd4;
            end
         end
         S_DRAIN: begin
            // The completing response is dropped by the high flush.
            if (fetch_resp_valid_i) begin
               pc_d    = new_pc_q;
               state_d = S_FLUSH;
               cnt_d   = FLUSH_INIT;
            end
         end
         S_FLUSH: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = 4'd0;
         end
      endcase

      // Registered view of the next state so flush/stall come straight from flops.
      flush_d = (state_d != S_RUN);
      stall_d = (state_d != S_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_RUN;
         cnt_q        <= 4'd0;
         pc_q         <= RESET_PC;
         new_pc_q     <= RESET_PC;
         flush_q      <= 1'b0;
         stall_q      <= 1'b0;
         trap_valid_q <= 1'b0;
         trap_pc_q    <= 64'd0;
         trap_tval_q  <= 64'd0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pc_q         <= pc_d;
         new_pc_q     <= new_pc_d;
         flush_q      <= flush_d;
         stall_q      <= stall_d;
         trap_valid_q <= trap_valid_d;
         trap_pc_q    <= trap_pc_d;
         trap_tval_q  <= trap_tval_d;
         count_q      <= count_d;
      end
   end

   assign pc_out_o         = pc_q;
   assign flush_o          = flush_q;
   assign stall_fetch_o    = stall_q;
   assign trap_valid_o     = trap_valid_q;
   assign trap_pc_o        = trap_pc_q;
   assign trap_tval_o      = trap_tval_q;
   assign redirect_count_o = count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed self-checking bench for pc_redirect_unit

module tb_pc_redirect_unit;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic        ex_jump;
   logic [63:0] ex_target;
   logic [63:0] ex_pc;
   logic        fetch_advance;
   logic        fetch_busy;
   logic        fetch_resp_valid;
   logic [63:0] pc_out;
   logic        flush;
   logic        stall_fetch;
   logic        trap_valid;
   logic [63:0] trap_pc;
   logic [63:0] trap_tval;
   logic [31:0] redirect_count;

   int n_checks = 0;
   int n_pass   = 0;

   pc_redirect_unit #(
      .RESET_PC     (64'h0),
      .TRAP_VECTOR  (64'h100),
      .FLUSH_CYCLES (2),
      .CNT_W        (32)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .ex_valid_i         (ex_valid),
      .ex_jump_i          (ex_jump),
      .ex_target_i        (ex_target),
      .ex_pc_i            (ex_pc),
      .fetch_advance_i    (fetch_advance),
      .fetch_busy_i       (fetch_busy),
      .fetch_resp_valid_i (fetch_resp_valid),
      .pc_out_o           (pc_out),
      .flush_o            (flush),
      .stall_fetch_o      (stall_fetch),
      .trap_valid_o       (trap_valid),
      .trap_pc_o          (trap_pc),
      .trap_tval_o        (trap_tval),
      .redirect_count_o   (redirect_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fs(input string tag, input logic f, input logic s);
      check({tag, "_flush"}, {63'd0, flush}, {63'd0, f});
      check({tag, "_stall"}, {63'd0, stall_fetch}, {63'd0, s});
   endtask

   task automatic redirect(input logic [63:0] tgt, input logic [63:0] jpc);
      ex_valid  = 1'b1;
      ex_jump   = 1'b1;
      ex_target = tgt;
      ex_pc     = jpc;
   endtask

   task automatic no_redirect();
      ex_valid  = 1'b0;
      ex_jump   = 1'b0;
      ex_target = 64'd0;
      ex_pc     = 64'd0;
   endtask

   initial begin
      reset            = 1'b1;
      fetch_advance    = 1'b0;
      fetch_busy       = 1'b0;
      fetch_resp_valid = 1'b0;
      no_redirect();
      #2;
      check("rst_pc", pc_out, 64'h0);
      fs("rst", 1'b0, 1'b0);
      check("rst_trap_valid", {63'd0, trap_valid}, 64'd0);
      check("rst_trap_pc", trap_pc, 64'h0);
      check("rst_trap_tval", trap_tval, 64'h0);
      check("rst_count", {32'd0, redirect_count}, 64'd0);
      step();
      step();
      reset = 1'b0;

      // Sequential advance
      fetch_advance = 1'b1;
      step(); check("adv1", pc_out, 64'h4); fs("adv1", 1'b0, 1'b0);
      step(); check("adv2", pc_out, 64'h8); fs("adv2", 1'b0, 1'b0);

      // ex_valid without jump has no effect
      ex_valid = 1'b1; ex_target = 64'h7000;
      step(); check("nojump_pc", pc_out, 64'hC);
      check("nojump_count", {32'd0, redirect_count}, 64'd0);
      no_redirect();
      step(); check("adv4", pc_out, 64'h10);

      // Redirect with a same-cycle advance: advance dropped
      redirect(64'h2000, 64'h10);
      step(); check("rd1_pc", pc_out, 64'h2000); fs("rd1_f1", 1'b1, 1'b1);
      check("rd1_count", {32'd0, redirect_count}, 64'd1);
      check("rd1_no_trap", {63'd0, trap_valid}, 64'd0);
      // Younger redirect during FLUSH is ignored
      redirect(64'h5000, 64'h2000);
      step(); check("ign_pc", pc_out, 64'h2000); fs("rd1_f2", 1'b1, 1'b1);
      check("ign_count", {32'd0, redirect_count}, 64'd1);
      no_redirect();
      // advance still held high: ignored during the last flush edge
      step(); check("rd1_end_pc", pc_out, 64'h2000); fs("rd1_end", 1'b0, 1'b0);
      step(); check("rd1_adv", pc_out, 64'h2004);
      fetch_advance = 1'b0;

      // Redirect while a fetch is outstanding
      fetch_busy = 1'b1;
      redirect(64'h3000, 64'h2004);
      step(); check("dr_pc0", pc_out, 64'h2004); fs("dr0", 1'b1, 1'b1);
      check("dr_count", {32'd0, redirect_count}, 64'd2);
      no_redirect();
      fetch_advance = 1'b1;
      step(); check("dr_pc1", pc_out, 64'h2004); fs("dr1", 1'b1, 1'b1);
      step(); check("dr_pc2", pc_out, 64'h2004); fs("dr2", 1'b1, 1'b1);
      fetch_resp_valid = 1'b1;
      step(); check("dr_pc3", pc_out, 64'h3000); fs("dr_f1", 1'b1, 1'b1);
      fetch_resp_valid = 1'b0;
      fetch_busy = 1'b0;
      step(); check("dr_f2_pc", pc_out, 64'h3000); fs("dr_f2", 1'b1, 1'b1);
      step(); check("dr_end_pc", pc_out, 64'h3000); fs("dr_end", 1'b0, 1'b0);
      // Back-to-back: misaligned redirect in the first RUN cycle
      fetch_advance = 1'b0;
      redirect(64'h2002, 64'h40);
      step(); check("tr_pc", pc_out, 64'h100);
      check("tr_valid", {63'd0, trap_valid}, 64'd1);
      check("tr_epc", trap_pc, 64'h40);
      check("tr_tval", trap_tval, 64'h2002);
      check("tr_count", {32'd0, redirect_count}, 64'd3);
      no_redirect();
      step(); check("tr_pulse_end", {63'd0, trap_valid}, 64'd0);
      check("tr_epc_hold", trap_pc, 64'h40);
      fs("tr_f2", 1'b1, 1'b1);
      step(); fs("tr_end", 1'b0, 1'b0);

      // Reset in the middle of DRAIN
      fetch_busy = 1'b1;
      redirect(64'h4000, 64'h100);
      step(); fs("rd_drain", 1'b1, 1'b1);
      no_redirect();
      step();
      #2;
      reset = 1'b1;
      #1;
      check("arst_pc", pc_out, 64'h0);
      fs("arst", 1'b0, 1'b0);
      check("arst_trap", {63'd0, trap_valid}, 64'd0);
      check("arst_count", {32'd0, redirect_count}, 64'd0);
      fetch_busy = 1'b0;
      fetch_resp_valid = 1'b1;
      step();
      fetch_resp_valid = 1'b0;
      reset = 1'b0;
      fetch_advance = 1'b1;
      step(); check("post_rst_pc", pc_out, 64'h4); fs("post_rst", 1'b0, 1'b0);
      step(); check("post_rst_pc2", pc_out, 64'h8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
